laser_rx_deserializer: RTL and testbench
========================================

# laser_rx_deserializer

Oversampling serial receiver for the photodiode input. It recovers bytes from the single-bit `laser_rx` line and presents each one as a one-cycle `data_valid` strobe with `data_in`. Downstream, the handshake FSM, the received-byte register and the sequence detector consume these strobes directly. It is the stage directly upstream of the top-level receive path and must match the transmitter framing: idle low, one start bit, 8 data bits LSB first, one stop bit.

## Interface
Parameters:
- `SAMPLES`, default 16: system clocks per bit (50 MHz / 3.125 MHz). Must be even and ≥ 4.

Ports:
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset. All state clears while it is 0.
- `en`  in  1  receiver enable. When 0, the FSM is held in IDLE and any frame in progress is discarded.
- `clear`  in  1  synchronous clear of `err_count`.
- `laser_in`  in  1  raw asynchronous photodiode line (1 = light).
- `data_valid`  out  1  one-cycle strobe when a byte has been received with a good stop bit.
- `data_in`  out  8  last good byte. Holds its value until the next `data_valid`.
- `frame_err`  out  1  one-cycle strobe when the stop bit is sampled as 1.
- `busy`  out  1  1 in any state other than IDLE.
- `err_count`  out  8  saturating count of `frame_err` events.

## Operation
- **Input conditioning**
  - Two-flop synchronizer produces `rx_s`.
  - A 3-bit shift register holds the last three `rx_s` values.
  - `vote` is the majority of those three bits.
- **Counters**
  - `samp_ct` has width $clog2(SAMPLES).
  - `bit_ct` is 3 bits.
- **FSM** (states IDLE, START, DATA, STOP):
  - **IDLE:** `samp_ct` = 0. On `en` && `rx_s`==1 with the previous `rx_s`==0 (rising edge), go to START.
  - **START:** `samp_ct` increments each cycle. At `samp_ct`==SAMPLES/2−1 (mid start bit):
    - `vote`==1 → go to DATA, `samp_ct`=0, `bit_ct`=0.
    - otherwise → go to IDLE (glitch rejected; no strobe, no error).
  - **DATA:** at `samp_ct`==SAMPLES−1:
    - Shift `vote` into the MSB of the shift register (so the byte lands LSB first).
    - `samp_ct`=0, `bit_ct`++.
    - If `bit_ct` was 7 → go to STOP.
  - **STOP:** at `samp_ct`==SAMPLES−1:
    - `vote`==0 → next cycle `data_valid`=1 and `data_in`=shift register.
    - `vote`==1 → next cycle `frame_err`=1, `data_in` unchanged, `err_count` increments.
    - In both cases go to IDLE at the mid-stop sample point. This leaves half a bit of margin for the next start edge.
- **en deasserted** in any state → IDLE on the next clock. No strobe is issued; the shift register contents are don't-care.
- **`err_count`:** saturates at 8'hFF and never wraps. If `clear` and a frame error occur in the same cycle, `clear` wins and the result is 0.
- **Back-to-back frames:** a start edge arriving while in IDLE immediately after STOP is accepted with no dead cycles.
- **Line stuck high:**
  - Stop bits fail, so `frame_err` fires once.
  - No new rising edge follows, so the block stays in IDLE with no further strobes until the line returns low and rises again.

## Timing
- **Reset values:**
  - `data_valid`=0, `frame_err`=0, `busy`=0, `data_in`=8'h00, `err_count`=8'h00.
  - FSM in IDLE; synchronizer, vote register and shift register all 0.
- **Strobe registration:** `data_valid` and `frame_err` are registered and mutually exclusive. Each is high for exactly one cycle per frame.
- **Latency:** with cycle 0 = first posedge that samples `laser_in`=1, `data_valid` rises at cycle 3 + SAMPLES/2 + 9·SAMPLES, i.e. 155 for SAMPLES=16. The bench tolerates ±1.
- **Transmitter clock tolerance:** ±3 % against the nominal SAMPLES clocks per bit.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronously). No strobe may be emitted in the first cycle after reset release.
- **Throughput:** one byte per 10·SAMPLES cycles.

## Test plan
- **Single byte:** frame 0x55, SAMPLES=16 → one `data_valid` at cycle 155±1 with `data_in`=8'h55; `frame_err` stays 0.
- **Back-to-back sequence:** frames C1,C2,C3,C4 with no idle gap → four `data_valid` pulses 160 cycles apart carrying 8'hC1, 8'hC2, 8'hC3, 8'hC4.
- **Glitch rejection:** `laser_in` high for 4 cycles, then low → `busy` pulses and returns to 0; no `data_valid`, no `frame_err`, `err_count`=0.
- **Bad stop bit:** frame 0xA1 with stop bit =1, followed by an idle line → `frame_err` one cycle, `err_count`=1, `data_in` keeps its previous value. Then assert `clear` → `err_count`=0.
- **Saturation:** 260 bad-stop frames → `err_count`=8'hFF, no wrap.
- **Abort paths:**
  - Drop `en` during bit 4 of a 0x3C frame → no strobe.
  - Re-enable, then send 0x3C → `data_valid` with 8'h3C.
  - Separately, pulse `reset` low mid-frame → all outputs 0 and the next frame is received correctly.

Source files
------------

// File: rtl/laser_rx_deserializer_if.sv
// Receive-side bundle for the photodiode deserializer: line/control inputs
// plus received-byte strobes and status.
interface laser_rx_deserializer_if;
    logic       en;
    logic       clear;
    logic       laser_in;
    logic       data_valid;
    logic [7:0] data_in;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    modport master (
        output en, clear, laser_in,
        input  data_valid, data_in, frame_err, busy, err_count
    );

    modport slave (
        input  en, clear, laser_in,
        output data_valid, data_in, frame_err, busy, err_count
    );
endinterface

// File: rtl/laser_rx_deserializer.sv
// Oversampling serial receiver: idle-low line, start bit 1, 8 data bits LSB
// first, stop bit 0. Majority-voted samples taken mid-bit.
module laser_rx_deserializer #(
    parameter int SAMPLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    laser_rx_deserializer_if.slave  rx
);
    localparam int CW = $clog2(SAMPLES);
    localparam logic [CW-1:0] MID_CT = CW'(SAMPLES / 2 - 1);
    localparam logic [CW-1:0] END_CT = CW'(SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q,      state_d;
    logic          sync1_q,      sync1_d;
    logic          rx_s_q,       rx_s_d;
    logic [2:0]    vote_sr_q,    vote_sr_d;
    logic [CW-1:0] samp_ct_q,    samp_ct_d;
    logic [2:0]    bit_ct_q,     bit_ct_d;
    logic [7:0]    shift_q,      shift_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q,  frame_err_d;
    logic [7:0]    data_in_q,    data_in_d;
    logic [7:0]    err_count_q,  err_count_d;

    logic vote;
    logic err_inc;

    assign vote = (vote_sr_q[0] & vote_sr_q[1]) |
                  (vote_sr_q[0] & vote_sr_q[2]) |
                  (vote_sr_q[1] & vote_sr_q[2]);

    always_comb begin
        state_d      = state_q;
        sync1_d      = rx.laser_in;
        rx_s_d       = sync1_q;
        vote_sr_d    = {vote_sr_q[1:0], rx_s_q};
        samp_ct_d    = samp_ct_q;
        bit_ct_d     = bit_ct_q;
        shift_d      = shift_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        data_in_d    = data_in_q;
        err_inc      = 1'b0;

        if (!rx.en) begin
            state_d   = IDLE;
            samp_ct_d = '0;
            bit_ct_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    samp_ct_d = '0;
                    // vote_sr_q[0] is the previous rx_s, so this is a rising edge
                    if (rx_s_q && !vote_sr_q[0]) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (samp_ct_q == MID_CT) begin
                        state_d   = vote ? DATA : IDLE;
                        samp_ct_d = '0;
                        bit_ct_d  = '0;
                    end else begin
                        samp_ct_d = samp_ct_q + CW'(1);
                    end
                end
                DATA: begin
                    if (samp_ct_q == END_CT) begin
                        shift_d   = {vote, shift_q[7:1]};
                        samp_ct_d = '0;
                        bit_ct_d  = bit_ct_q + 3'd1;
                        if (bit_ct_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        samp_ct_d = samp_ct_q + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives half a bit to catch the next start edge
                    if (samp_ct_q == END_CT) begin
                        samp_ct_d = '0;
                        state_d   = IDLE;
                        if (!vote) begin
                            data_valid_d = 1'b1;
                            data_in_d    = shift_q;
                        end else begin
                            frame_err_d = 1'b1;
                            err_inc     = 1'b1;
                        end
                    end else begin
                        samp_ct_d = samp_ct_q + CW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    samp_ct_d = '0;
                end
            endcase
        end

        if (rx.clear) begin
            err_count_d = 8'h00;
        end else if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            rx_s_q       <= 1'b0;
            vote_sr_q    <= 3'b000;
            samp_ct_q    <= '0;
            bit_ct_q     <= 3'd0;
            shift_q      <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            data_in_q    <= 8'h00;
            err_count_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            vote_sr_q    <= vote_sr_d;
            samp_ct_q    <= samp_ct_d;
            bit_ct_q     <= bit_ct_d;
            shift_q      <= shift_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            data_in_q    <= data_in_d;
            err_count_q  <= err_count_d;
        end
    end

    assign rx.data_valid = data_valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.data_in    = data_in_q;
    assign rx.err_count  = err_count_q;
    assign rx.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_laser_rx_deserializer.sv
// Scoreboard bench: driver pushes expected strobes per frame, monitor pops on
// every data_valid/frame_err and compares data, kind and error count.
module tb_laser_rx_deserializer;
    localparam int SAMPLES = 16;
    localparam int NOM     = SAMPLES * 100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    laser_rx_deserializer_if rx_if ();

    laser_rx_deserializer #(.SAMPLES(SAMPLES)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_cycs[$];
    int   total = 0;
    int   bad   = 0;
    logic [7:0] model_last = 8'h00;
    int   model_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int req, input int tol);
        total++;
        if (act < req - tol || act > req + tol) begin
            bad++;
            $display("FAIL %s: got %0d required %0d +/- %0d", name, act, req, tol);
        end
    endtask

    // Reference behaviour: a good frame updates the last byte; a bad stop keeps it
    // and bumps a saturating error count unless clear is held.
    task automatic push_exp(input logic err, input logic [7:0] b, input logic clr);
        exp_t e;
        if (err) begin
            if (model_cnt < 255) model_cnt++;
        end else begin
            model_last = b;
        end
        if (clr) model_cnt = 0;
        e.err  = err;
        e.data = model_last;
        e.cnt  = model_cnt[7:0];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rx_if.laser_in = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Bit period given in 1/100 cycle units; abort_k drops en halfway through bit abort_k.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int per, input int abort_k);
        logic [9:0] bits;
        int prev;
        int nxt;
        int dur;
        bits = {stop, b, 1'b1};
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            nxt  = ((k + 1) * per + 50) / 100;
            dur  = nxt - prev;
            prev = nxt;
            rx_if.laser_in = bits[k];
            if (k == abort_k) begin
                repeat (dur / 2) @(negedge clock);
                rx_if.en = 1'b0;
                repeat (dur - dur / 2) @(negedge clock);
            end else begin
                repeat (dur) @(negedge clock);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset && (rx_if.data_valid || rx_if.frame_err)) begin
            exp_t e;
            check("strobe_exclusive", int'(rx_if.data_valid & rx_if.frame_err), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", int'({rx_if.data_valid, rx_if.frame_err}), 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", int'(rx_if.frame_err), int'(e.err));
                check("strobe_data", int'(rx_if.data_in), int'(e.data));
                check("strobe_err_count", int'(rx_if.err_count), int'(e.cnt));
                $display("strobe cyc=%0d err=%0b data=%02h cnt=%0d", cyc, rx_if.frame_err, rx_if.data_in, rx_if.err_count);
            end
            strobe_cycs.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n0;
        logic saw_busy;
        logic [7:0] b;
        logic good;

        rx_if.en       = 1'b0;
        rx_if.clear    = 1'b0;
        rx_if.laser_in = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_data_valid", int'(rx_if.data_valid), 0);
        check("rst_frame_err",  int'(rx_if.frame_err), 0);
        check("rst_busy",       int'(rx_if.busy), 0);
        check("rst_data_in",    int'(rx_if.data_in), 0);
        check("rst_err_count",  int'(rx_if.err_count), 0);
        reset    = 1'b1;
        rx_if.en = 1'b1;
        idle(20);

        // Single byte with latency
        t0 = cyc;
        n0 = strobe_cycs.size();
        push_exp(1'b0, 8'h55, 1'b0);
        send_frame(8'h55, 1'b0, NOM, -1);
        idle(40);
        check("single_count", strobe_cycs.size() - n0, 1);
        if (strobe_cycs.size() > n0) check_tol("latency", strobe_cycs[n0] - t0, 155, 1);

        // Back-to-back
        n0 = strobe_cycs.size();
        for (int i = 0; i < 4; i++) begin
            b = 8'hC1 + 8'(i);
            push_exp(1'b0, b, 1'b0);
            send_frame(b, 1'b0, NOM, -1);
        end
        idle(40);
        check("b2b_count", strobe_cycs.size() - n0, 4);
        if (strobe_cycs.size() >= n0 + 4) begin
            for (int i = 1; i < 4; i++) check_tol("b2b_spacing", strobe_cycs[n0 + i] - strobe_cycs[n0 + i - 1], 160, 1);
        end

        // Glitch rejection
        saw_busy = 1'b0;
        rx_if.laser_in = 1'b1;
        repeat (4) @(negedge clock);
        rx_if.laser_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rx_if.busy) saw_busy = 1'b1;
            @(negedge clock);
        end
        check("glitch_busy_seen", int'(saw_busy), 1);
        check("glitch_busy_end",  int'(rx_if.busy), 0);
        check("glitch_err_count", int'(rx_if.err_count), 0);

        // Bad stop, then clear
        push_exp(1'b1, 8'hA1, 1'b0);
        send_frame(8'hA1, 1'b1, NOM, -1);
        idle(32);
        check("badstop_err_count", int'(rx_if.err_count), 1);
        check("badstop_data_kept", int'(rx_if.data_in), int'(model_last));
        rx_if.clear = 1'b1;
        @(negedge clock);
        rx_if.clear = 1'b0;
        model_cnt = 0;
        check("clear_err_count", int'(rx_if.err_count), 0);

        // Randomized frames with +/-3 % bit period
        for (int i = 0; i < 20; i++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            push_exp(!good, b, 1'b0);
            send_frame(b, !good, int'($urandom_range(NOM - 48, NOM + 48)), -1);
            idle(good ? int'($urandom_range(0, 30)) : int'($urandom_range(8, 30)));
        end
        idle(40);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            b = 8'($urandom_range(0, 255));
            push_exp(1'b1, b, 1'b0);
            send_frame(b, 1'b1, NOM, -1);
            idle(16);
        end
        check("sat_err_count", int'(rx_if.err_count), 255);

        // Clear held across a frame error: clear wins
        rx_if.clear = 1'b1;
        push_exp(1'b1, 8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1, NOM, -1);
        idle(16);
        rx_if.clear = 1'b0;
        check("clear_wins", int'(rx_if.err_count), 0);
        push_exp(1'b1, 8'h11, 1'b0);
        send_frame(8'h11, 1'b1, NOM, -1);
        idle(16);

        // Drop en during data bit 4
        send_frame(8'h3C, 1'b0, NOM, 5);
        idle(20);
        check("abort_busy", int'(rx_if.busy), 0);
        rx_if.en = 1'b1;
        idle(10);
        push_exp(1'b0, 8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, NOM, -1);
        idle(40);
        check("reenable_data", int'(rx_if.data_in), 8'h3C);

        // Asynchronous reset mid-frame
        fork
            send_frame(8'h77, 1'b0, NOM, -1);
            begin
                repeat (60) @(negedge clock);
                #2 reset = 1'b0;
                #1;
                check("midrst_data_valid", int'(rx_if.data_valid), 0);
                check("midrst_frame_err",  int'(rx_if.frame_err), 0);
                check("midrst_busy",       int'(rx_if.busy), 0);
                check("midrst_data_in",    int'(rx_if.data_in), 0);
                check("midrst_err_count",  int'(rx_if.err_count), 0);
            end
        join
        model_last = 8'h00;
        model_cnt  = 0;
        idle(5);
        reset = 1'b1;
        idle(10);
        push_exp(1'b0, 8'h96, 1'b0);
        send_frame(8'h96, 1'b0, NOM, -1);
        idle(40);
        check("post_reset_data", int'(rx_if.data_in), 8'h96);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
